// File: rtl/edge_event_arbiter.sv
// ============================================================================
// Module   : edge_event_arbiter
// Purpose  : Per-line saturating event counters feeding a round-robin
//            valid/ready stream of event indices.
// Options  : EDGE_EVENT_ARB_BURST_EN adds evt_cnt_o and drains a whole line
//            per handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_event_arbiter #(
   parameter int NB_EVENTS = 4,
   parameter int CNT_WIDTH = 4,
   parameter int ID_WIDTH  = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clear_i,
   input  logic [NB_EVENTS-1:0]  event_i,
   output logic                  evt_valid_o,
   input  logic                  evt_ready_i,
   output logic [ID_WIDTH-1:0]   evt_id_o,
`ifdef EDGE_EVENT_ARB_BURST_EN
   output logic [CNT_WIDTH-1:0]  evt_cnt_o,
`endif
   output logic [NB_EVENTS-1:0]  overflow_o,
   input  logic [NB_EVENTS-1:0]  clear_ovf_i,
   output logic [NB_EVENTS-1:0]  pending_o
);

   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);
   localparam logic [ID_WIDTH-1:0]  C_ID_LAST = ID_WIDTH'(NB_EVENTS - 1);

   logic [NB_EVENTS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [NB_EVENTS-1:0]                ovf_q, ovf_d;
   logic                                valid_q, valid_d;
   logic [ID_WIDTH-1:0]                 id_q, id_d;
   logic [ID_WIDTH-1:0]                 ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]                evt_cnt_q, evt_cnt_d;

   logic [NB_EVENTS-1:0]                pend;
   logic [NB_EVENTS-1:0]                dec;
   logic [NB_EVENTS-1:0]                ovf_set;
   logic [ID_WIDTH-1:0]                 lo_win, hi_win, winner;
   logic                                hi_found;
   logic                                any_pend;
   logic                                stage_free;
   logic                                load;
   logic [CNT_WIDTH-1:0]                win_cnt;

   genvar gj;
   generate
      for (gj = 0; gj < NB_EVENTS; gj++) begin : g_pending
         assign pend[gj] = |cnt_q[gj];
      end
   endgenerate

   assign any_pend   = |pend;
   assign stage_free = !valid_q || evt_ready_i;
   assign load       = stage_free && any_pend;

   // Lowest pending line at or above the pointer wins; otherwise wrap to the lowest pending.
   always_comb begin
      lo_win   = '0;
      hi_win   = '0;
      hi_found = 1'b0;
      for (int i = NB_EVENTS - 1; i >= 0; i--) begin
         if (pend[i]) begin
            lo_win = ID_WIDTH'(i);
            if (i >= int'(ptr_q)) begin
               hi_win   = ID_WIDTH'(i);
               hi_found = 1'b1;
            end
         end
      end
      winner = hi_found ? hi_win : lo_win;
   end

   always_comb begin
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      evt_cnt_d = evt_cnt_q;
      dec       = '0;
      ovf_set   = '0;
      win_cnt   = '0;

      for (int j = 0; j < NB_EVENTS; j++) begin
         dec[j] = load && (winner == ID_WIDTH'(j));
         if (dec[j]) begin
            win_cnt = cnt_q[j];
         end
`ifdef EDGE_EVENT_ARB_BURST_EN
         if (dec[j]) begin
            cnt_d[j] = event_i[j] ? C_CNT_ONE : '0;
         end
`else
         if (dec[j] && !event_i[j]) begin
            cnt_d[j] = cnt_q[j] - C_CNT_ONE;
         end
`endif
         else if (!dec[j] && event_i[j]) begin
            if (cnt_q[j] == C_CNT_MAX) begin
               ovf_set[j] = 1'b1;
            end else begin
               cnt_d[j] = cnt_q[j] + C_CNT_ONE;
            end
         end
         ovf_d[j] = (ovf_q[j] && !clear_ovf_i[j]) || ovf_set[j];
      end

      if (stage_free) begin
         valid_d = any_pend;
         if (load) begin
            id_d      = winner;
            ptr_d     = (winner == C_ID_LAST) ? '0 : winner + ID_WIDTH'(1);
            evt_cnt_d = win_cnt;
         end
      end

      if (clear_i) begin
         cnt_d   = '0;
         ovf_d   = '0;
         valid_d = 1'b0;
         ptr_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q     <= '0;
         ovf_q     <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         ptr_q     <= '0;
         evt_cnt_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         ptr_q     <= ptr_d;
         evt_cnt_q <= evt_cnt_d;
      end
   end

   assign evt_valid_o = valid_q;
   assign evt_id_o    = id_q;
   assign overflow_o  = ovf_q;
   assign pending_o   = pend;

`ifdef EDGE_EVENT_ARB_BURST_EN
   assign evt_cnt_o = evt_cnt_q;
`else
   logic unused_evt_cnt;
   assign unused_evt_cnt = ^evt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// ============================================================================
// Module   : tb_edge_event_arbiter
// Purpose  : Directed plus randomized bench for edge_event_arbiter against a
//            count-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_event_arbiter;

   localparam int NB_EVENTS = 4;
   localparam int CNT_WIDTH = 4;
   localparam int ID_WIDTH  = 2;
   localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

   logic                  clk_i = 1'b0;
   logic                  rstn_i;
   logic                  clear_i;
   logic [NB_EVENTS-1:0]  event_i;
   logic                  evt_valid_o;
   logic                  evt_ready_i;
   logic [ID_WIDTH-1:0]   evt_id_o;
   logic [CNT_WIDTH-1:0]  evt_cnt_o;
   logic [NB_EVENTS-1:0]  overflow_o;
   logic [NB_EVENTS-1:0]  clear_ovf_i;
   logic [NB_EVENTS-1:0]  pending_o;

   edge_event_arbiter #(
      .NB_EVENTS (NB_EVENTS),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .clear_i     (clear_i),
      .event_i     (event_i),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_id_o    (evt_id_o),
`ifdef EDGE_EVENT_ARB_BURST_EN
      .evt_cnt_o   (evt_cnt_o),
`endif
      .overflow_o  (overflow_o),
      .clear_ovf_i (clear_ovf_i),
      .pending_o   (pending_o)
   );

`ifndef EDGE_EVENT_ARB_BURST_EN
   assign evt_cnt_o = '0;
`endif

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: plain integer event counts per line.
   int m_cnt [NB_EVENTS];
   bit m_ovf [NB_EVENTS];
   bit m_valid;
   int m_id;
   int m_ptr;
   int m_evt_cnt;

   task automatic model_reset();
      for (int j = 0; j < NB_EVENTS; j++) begin
         m_cnt[j] = 0;
         m_ovf[j] = 1'b0;
      end
      m_valid   = 1'b0;
      m_id      = 0;
      m_ptr     = 0;
      m_evt_cnt = 0;
   endtask

   task automatic model_step(input logic [NB_EVENTS-1:0] ev, input logic rdy,
                             input logic clr, input logic [NB_EVENTS-1:0] cov);
      bit free, found;
      int w, taken, c, grabbed;
      if (clr) begin
         for (int j = 0; j < NB_EVENTS; j++) begin
            m_cnt[j] = 0;
            m_ovf[j] = 1'b0;
         end
         m_valid = 1'b0;
         m_ptr   = 0;
         return;
      end
      free  = !m_valid || rdy;
      found = 1'b0;
      w     = 0;
      for (int k = 0; k < NB_EVENTS; k++) begin
         int j;
         j = (m_ptr + k) % NB_EVENTS;
         if (!found && m_cnt[j] > 0) begin
            found = 1'b1;
            w     = j;
         end
      end
      grabbed = m_cnt[w];
      for (int j = 0; j < NB_EVENTS; j++) begin
         bit lost;
         taken = 0;
         if (free && found && j == w) begin
`ifdef EDGE_EVENT_ARB_BURST_EN
            taken = m_cnt[j];
`else
            taken = 1;
`endif
         end
         c    = m_cnt[j] - taken + int'(ev[j]);
         lost = (c > CNT_MAX);
         if (lost) c = CNT_MAX;
         m_cnt[j] = c;
         m_ovf[j] = (m_ovf[j] && !cov[j]) || lost;
      end
      if (free) begin
         m_valid = found;
         if (found) begin
            m_id      = w;
            m_ptr     = (w + 1) % NB_EVENTS;
            m_evt_cnt = grabbed;
         end
      end
   endtask

   task automatic compare_all();
      logic [NB_EVENTS-1:0] ep, eo;
      for (int j = 0; j < NB_EVENTS; j++) begin
         ep[j] = (m_cnt[j] != 0);
         eo[j] = m_ovf[j];
      end
      check("valid", 32'(evt_valid_o), 32'(m_valid));
      if (m_valid) begin
         check("id", 32'(evt_id_o), 32'(m_id));
`ifdef EDGE_EVENT_ARB_BURST_EN
         check("evt_cnt", 32'(evt_cnt_o), 32'(m_evt_cnt));
`endif
      end
      check("pending", 32'(pending_o), 32'(ep));
      check("overflow", 32'(overflow_o), 32'(eo));
   endtask

   int hs_count;

   task automatic cycle(input logic [NB_EVENTS-1:0] ev, input logic rdy,
                        input logic clr, input logic [NB_EVENTS-1:0] cov);
      event_i     = ev;
      evt_ready_i = rdy;
      clear_i     = clr;
      clear_ovf_i = cov;
      if (evt_valid_o && rdy && !clr && evt_id_o == ID_WIDTH'(1)) hs_count++;
      model_step(ev, rdy, clr, cov);
      @(posedge clk_i);
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      event_i     = '0;
      evt_ready_i = 1'b0;
      clear_i     = 1'b0;
      clear_ovf_i = '0;
      rstn_i      = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      model_reset();
      rstn_i = 1'b1;
   endtask

   initial begin
      int rdy_pct;
      logic [NB_EVENTS-1:0] ev, cov;
      logic [ID_WIDTH-1:0] rr_exp [4];
      rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3;
      hs_count = 0;

      apply_reset();
      check("reset_valid", 32'(evt_valid_o), 32'd0);
      check("reset_id", 32'(evt_id_o), 32'd0);
      check("reset_pending", 32'(pending_o), 32'd0);
      check("reset_overflow", 32'(overflow_o), 32'd0);

      // single event on line 2
      cycle(4'b0100, 1'b0, 1'b0, 4'b0000);
      check("single_not_yet", 32'(evt_valid_o), 32'd0);
      cycle(4'b0000, 1'b0, 1'b0, 4'b0000);
      check("single_valid", 32'(evt_valid_o), 32'd1);
      check("single_id", 32'(evt_id_o), 32'd2);
      repeat (10) cycle(4'b0000, 1'b0, 1'b0, 4'b0000);
      check("single_hold_valid", 32'(evt_valid_o), 32'd1);
      check("single_hold_id", 32'(evt_id_o), 32'd2);
      cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
      check("single_drain_valid", 32'(evt_valid_o), 32'd0);
      check("single_drain_pend", 32'(pending_o), 32'd0);

      // round robin
      apply_reset();
      cycle(4'b1111, 1'b1, 1'b0, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
         check("rr_id", 32'(evt_id_o), 32'(rr_exp[k]));
      end
      cycle(4'b1001, 1'b1, 1'b0, 4'b0000);
      check("rr_gap_valid", 32'(evt_valid_o), 32'd0);
      cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
      check("rr2_first", 32'(evt_id_o), 32'd0);
      cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
      check("rr2_second", 32'(evt_id_o), 32'd3);

      // saturation on line 1
      apply_reset();
      repeat (17) cycle(4'b0010, 1'b0, 1'b0, 4'b0000);
      check("sat_overflow", 32'(overflow_o[1]), 32'd1);
      hs_count = 0;
      repeat (20) cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
`ifdef EDGE_EVENT_ARB_BURST_EN
      check("sat_handshakes", 32'(hs_count), 32'd2);
`else
      check("sat_handshakes", 32'(hs_count), 32'd16);
`endif
      cycle(4'b0000, 1'b0, 1'b0, 4'b0010);
      check("sat_ovf_cleared", 32'(overflow_o[1]), 32'd0);

      // increment and load on a saturated line in the same cycle
      repeat (17) cycle(4'b0010, 1'b0, 1'b0, 4'b0000);
      cycle(4'b0000, 1'b0, 1'b0, 4'b0010);
      cycle(4'b0010, 1'b1, 1'b0, 4'b0000);
      check("satsim_no_ovf", 32'(overflow_o[1]), 32'd0);
      check("satsim_valid", 32'(evt_valid_o), 32'd1);
      check("satsim_id", 32'(evt_id_o), 32'd1);

      // synchronous clear beats events
      cycle(4'b1111, 1'b0, 1'b0, 4'b0000);
      cycle(4'b0000, 1'b0, 1'b0, 4'b0000);
      cycle(4'b1111, 1'b1, 1'b1, 4'b0000);
      check("clear_valid", 32'(evt_valid_o), 32'd0);
      check("clear_pending", 32'(pending_o), 32'd0);
      check("clear_overflow", 32'(overflow_o), 32'd0);

      // burst-style accumulation on line 3
      apply_reset();
      repeat (5) cycle(4'b1000, 1'b0, 1'b0, 4'b0000);
      repeat (8) cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
      check("burst_drained", 32'(evt_valid_o), 32'd0);

      // randomized traffic
      rdy_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 64 == 0) begin
            case ($urandom_range(3))
               0: rdy_pct = 0;
               1: rdy_pct = 30;
               2: rdy_pct = 70;
               default: rdy_pct = 100;
            endcase
         end
         ev  = NB_EVENTS'($urandom) & NB_EVENTS'($urandom);
         cov = ($urandom_range(9) == 0) ? NB_EVENTS'($urandom) : '0;
         cycle(ev, ($urandom_range(99) < rdy_pct), ($urandom_range(199) == 0), cov);
      end

      // asynchronous reset while an event is presented
      cycle(4'b0001, 1'b0, 1'b0, 4'b0000);
      cycle(4'b0000, 1'b0, 1'b0, 4'b0000);
      check("pre_async_valid", 32'(evt_valid_o), 32'd1);
      #2;
      rstn_i = 1'b0;
      #1;
      check("async_valid", 32'(evt_valid_o), 32'd0);
      check("async_pending", 32'(pending_o), 32'd0);
      model_reset();
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      cycle(4'b0000, 1'b1, 1'b0, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
